// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } pwm_state_t;

    // Duty is reported in whole percent, 0..100, which fits in 7 bits.
    localparam int PCT_W      = 7;
    localparam int DUTY_SCALE = 100;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring binary divider, one quotient bit per clock.
// A start loads the operands and restarts any division in progress.
// o_done pulses for one cycle together with the final quotient.
module pwm_duty_div #(
    parameter int NUM_W = 15,
    parameter int DEN_W = 8,
    parameter int QUO_W = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [QUO_W-1:0] o_quo
);

    localparam int STEP_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0]  r_rem;
    logic [DEN_W-1:0]  r_den;
    logic [NUM_W-1:0]  r_quo;
    logic [STEP_W-1:0] r_step;
    logic              r_busy;
    logic              r_done;

    logic [DEN_W:0]    w_shift;
    logic              w_ge;
    logic [DEN_W-1:0]  w_diff;

    // The partial remainder is always below the divisor, so DEN_W bits hold it
    // and the subtraction can be done modulo 2**DEN_W.
    assign w_shift = {r_rem, r_quo[NUM_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_den});
    assign w_diff  = w_shift[DEN_W-1:0] - r_den;

    // Iteration: remainder and quotient shift left together, one bit per cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quo  <= '0;
            r_step <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_abort) begin
            r_step <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_den  <= i_den;
            r_quo  <= i_num;
            r_step <= STEP_W'(NUM_W);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff : w_shift[DEN_W-1:0];
            r_quo  <= {r_quo[NUM_W-2:0], w_ge};
            r_step <= r_step - STEP_W'(1);
            r_busy <= (r_step != STEP_W'(1));
            r_done <= (r_step == STEP_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_quo  = r_quo[QUO_W-1:0];

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM line in CLK cycles and
// reports {period, high, duty%} once per completed period on a valid/ready port.
//
// state | meaning
// IDLE  | capture disabled, counters cleared
// ARM   | waiting for the rise that opens the first period
// RUN   | counting; each rise closes one period and opens the next
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_en,
    input  logic             i_pwm_in,
    output logic [CNT_W-1:0] o_meas_period,
    output logic [CNT_W-1:0] o_meas_high,
    output logic [PCT_W-1:0] o_meas_duty,
    output logic             o_meas_valid,
    input  logic             i_meas_ready,
    output logic             o_overrun,
    output logic             o_timeout
);

    localparam int               NUM_W   = CNT_W + PCT_W;
    localparam logic [CNT_W-1:0] PER_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    pwm_state_t             r_state;
    logic [CNT_W-1:0]       r_per_cnt;
    logic [CNT_W-1:0]       r_hi_cnt;
    logic                   r_hi_open;
    logic                   r_timeout;
    logic [CNT_W-1:0]       r_out_per;
    logic [CNT_W-1:0]       r_out_hi;
    logic [PCT_W-1:0]       r_out_duty;
    logic                   r_valid;
    logic                   r_overrun;
    logic [CNT_W-1:0]       r_div_per;
    logic [CNT_W-1:0]       r_div_hi;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_close;
    logic                   w_div_start;
    logic                   w_cap_drop;
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [PCT_W-1:0]       w_div_quo;
    logic [NUM_W-1:0]       w_div_num;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // A rise in RUN closes the running period; it is measured only if the divider is free.
    assign w_close     = i_en && (r_state == RUN) && w_rise;
    assign w_div_start = w_close && !w_div_busy;
    assign w_cap_drop  = w_close && w_div_busy;
    assign w_div_num   = {{PCT_W{1'b0}}, r_hi_cnt} * NUM_W'(DUTY_SCALE);

    // Synchroniser chain plus one extra flop for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
            r_s_d  <= w_s;
        end
    end

    // Sequencing FSM with period/high counters and the timeout flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_hi_open <= 1'b0;
            r_timeout <= 1'b0;
        end else if (!i_en) begin
            r_state   <= IDLE;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_hi_open <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_state <= ARM;
                ARM: begin
                    if (w_rise) begin
                        r_per_cnt <= CNT_W'(1);
                        r_hi_cnt  <= CNT_W'(1);
                        r_hi_open <= 1'b1;
                        r_timeout <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_rise) begin
                        r_per_cnt <= CNT_W'(1);
                        r_hi_cnt  <= CNT_W'(1);
                        r_hi_open <= 1'b1;
                        r_timeout <= 1'b0;
                    end else if (r_per_cnt == PER_MAX) begin
                        // No rise for a full counter range: line stuck high or low.
                        r_timeout <= 1'b1;
                        r_state   <= ARM;
                    end else begin
                        r_per_cnt <= r_per_cnt + CNT_W'(1);
                        if (w_s && r_hi_open) begin
                            r_hi_cnt <= r_hi_cnt + CNT_W'(1);
                        end
                        if (w_fall) begin
                            r_hi_open <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Keep the captured period/high alongside the divider so they publish together with duty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div_per <= '0;
            r_div_hi  <= '0;
        end else if (w_div_start) begin
            r_div_per <= r_per_cnt;
            r_div_hi  <= r_hi_cnt;
        end
    end

    pwm_duty_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W),
        .QUO_W (PCT_W)
    ) u_div (
        .CLK     (CLK),
        .RST     (RST),
        .i_start (w_div_start),
        .i_abort (!i_en),
        .i_num   (w_div_num),
        .i_den   (r_per_cnt),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_quo   (w_div_quo)
    );

    // Output register, handshake and sticky overrun; a held result survives EN=0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_per  <= '0;
            r_out_hi   <= '0;
            r_out_duty <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_valid && i_meas_ready) begin
                r_valid <= 1'b0;
            end
            if (!i_en) begin
                r_overrun <= 1'b0;
            end else begin
                if (w_cap_drop) begin
                    r_overrun <= 1'b1;
                end
                if (w_div_done) begin
                    if (!r_valid || i_meas_ready) begin
                        r_out_per  <= r_div_per;
                        r_out_hi   <= r_div_hi;
                        r_out_duty <= w_div_quo;
                        r_valid    <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_meas_period = r_out_per;
    assign o_meas_high   = r_out_hi;
    assign o_meas_duty   = r_out_duty;
    assign o_meas_valid  = r_valid;
    assign o_overrun     = r_overrun;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a background PWM source drives the input on
// falling clock edges, a single initial block walks through the scenarios.
module tb_pwm_capture;

    localparam int CNT_W = 8;
    // Input rise at a falling edge -> two sync flops -> capture edge -> 16-cycle divide/load.
    localparam int LAT   = 19;

    logic             CLK;
    logic             RST;
    logic             i_en;
    logic             i_pwm_in;
    logic             i_meas_ready;
    logic [CNT_W-1:0] o_meas_period;
    logic [CNT_W-1:0] o_meas_high;
    logic [6:0]       o_meas_duty;
    logic             o_meas_valid;
    logic             o_overrun;
    logic             o_timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int g_mode   = 0;
    int g_per    = 10;
    int g_hi     = 3;
    int ph       = 0;
    int rise_cnt = 0;
    int rise_at[256];
    int b;
    int k;
    int vcnt;

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .i_en          (i_en),
        .i_pwm_in      (i_pwm_in),
        .o_meas_period (o_meas_period),
        .o_meas_high   (o_meas_high),
        .o_meas_duty   (o_meas_duty),
        .o_meas_valid  (o_meas_valid),
        .i_meas_ready  (i_meas_ready),
        .o_overrun     (o_overrun),
        .o_timeout     (o_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // PWM source: g_mode=0 holds the line low, otherwise g_per/g_hi waveform.
    initial begin
        i_pwm_in = 1'b0;
        forever begin
            @(negedge CLK);
            if (g_mode == 0) begin
                i_pwm_in = 1'b0;
                ph = 0;
            end else begin
                if (ph == 0) begin
                    rise_at[rise_cnt % 256] = cyc;
                    rise_cnt++;
                end
                i_pwm_in = (ph < g_hi);
                ph = (ph + 1 >= g_per) ? 0 : ph + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int lim, input string tag);
        int n = 0;
        while (o_meas_valid !== 1'b1 && n < lim) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, o_meas_valid, 1);
    endtask

    task automatic wait_rise(input int after, input int lim, input string tag);
        int n = 0;
        while (rise_cnt <= after && n < lim) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, (rise_cnt > after), 1);
    endtask

    task automatic chk_result(input string tag, input int per, input int hi, input int duty);
        chk({tag, "_period"}, o_meas_period, per);
        chk({tag, "_high"},   o_meas_high,   hi);
        chk({tag, "_duty"},   o_meas_duty,   duty);
    endtask

    // Restart capture on a fresh waveform and check the first result and its latency.
    task automatic meas(input int per, input int hi, input int duty, input string tag);
        int base;
        i_en   = 1'b0;
        g_mode = 0;
        repeat (3) @(negedge CLK);
        g_per = per;
        g_hi  = hi;
        i_en  = 1'b1;
        repeat (2) @(negedge CLK);
        base   = rise_cnt;
        g_mode = 1;
        wait_valid(3 * per + 40, {tag, "_valid"});
        chk({tag, "_latency"}, cyc - rise_at[(base + 1) % 256], LAT);
        chk_result(tag, per, hi, duty);
    endtask

    initial begin
        RST          = 1'b1;
        i_en         = 1'b0;
        i_meas_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_valid",   o_meas_valid,  0);
        chk("rst_period",  o_meas_period, 0);
        chk("rst_high",    o_meas_high,   0);
        chk("rst_duty",    o_meas_duty,   0);
        chk("rst_overrun", o_overrun,     0);
        chk("rst_timeout", o_timeout,     0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: period 10 / high 3, consumer always ready
        i_meas_ready = 1'b1;
        meas(10, 3, 30, "t1");
        @(negedge CLK);
        chk("t1_valid_one_cycle", o_meas_valid, 0);
        wait_valid(40, "t1_valid2");
        chk_result("t1_second", 10, 3, 30);

        // 2: truncating duty and the minimum period
        meas(7, 2, 28, "t2a");
        meas(2, 1, 50, "t2b");

        // 3: consumer stalls for several periods
        i_en   = 1'b0;
        g_mode = 0;
        repeat (3) @(negedge CLK);
        i_meas_ready = 1'b0;
        g_per = 40;
        g_hi  = 10;
        i_en  = 1'b1;
        repeat (2) @(negedge CLK);
        g_mode = 1;
        wait_valid(150, "t3_valid");
        chk_result("t3_first", 40, 10, 25);
        chk("t3_no_overrun_yet", o_overrun, 0);
        repeat (120) @(negedge CLK);
        chk("t3_held_valid", o_meas_valid, 1);
        chk_result("t3_held", 40, 10, 25);
        chk("t3_overrun", o_overrun, 1);
        b = rise_cnt;
        wait_rise(b, 60, "t3_rise");
        repeat (25) @(negedge CLK);
        i_meas_ready = 1'b1;
        @(negedge CLK);
        chk("t3_accepted", o_meas_valid, 0);

        // 4: line stuck low after one rise, then recovery
        i_en   = 1'b0;
        g_mode = 0;
        repeat (3) @(negedge CLK);
        g_per = 10;
        g_hi  = 3;
        i_en  = 1'b1;
        repeat (2) @(negedge CLK);
        b      = rise_cnt;
        g_mode = 1;
        wait_rise(b, 20, "t4_first_rise");
        g_mode = 0;
        vcnt   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (o_meas_valid === 1'b1) vcnt++;
        end
        chk("t4_timeout_not_early", o_timeout, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (o_meas_valid === 1'b1) vcnt++;
        end
        chk("t4_timeout", o_timeout, 1);
        chk("t4_no_valid", vcnt, 0);
        b      = rise_cnt;
        g_mode = 1;
        wait_rise(b, 20, "t4_resume_rise");
        repeat (4) @(negedge CLK);
        chk("t4_timeout_cleared", o_timeout, 0);
        wait_valid(60, "t4_valid");
        chk("t4_latency", cyc - rise_at[(b + 1) % 256], LAT);
        chk_result("t4", 10, 3, 30);

        // 5: asynchronous reset while a result is held and a divide is running
        i_meas_ready = 1'b0;
        repeat (30) @(negedge CLK);
        chk("t5_pre_valid",   o_meas_valid, 1);
        chk("t5_pre_overrun", o_overrun,    1);
        b = rise_cnt;
        wait_rise(b, 20, "t5_rise");
        repeat (8) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("t5_async_valid",   o_meas_valid,  0);
        chk("t5_async_period",  o_meas_period, 0);
        chk("t5_async_high",    o_meas_high,   0);
        chk("t5_async_duty",    o_meas_duty,   0);
        chk("t5_async_overrun", o_overrun,     0);
        chk("t5_async_timeout", o_timeout,     0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t5_no_stale_valid", o_meas_valid, 0);

        // 6: disable with overrun and timeout set, then re-enable
        wait_valid(80, "t6_valid");
        repeat (30) @(negedge CLK);
        chk("t6_overrun", o_overrun, 1);
        g_mode = 0;
        repeat (300) @(negedge CLK);
        chk("t6_timeout", o_timeout, 1);
        i_en = 1'b0;
        @(negedge CLK);
        chk("t6_overrun_cleared", o_overrun,    0);
        chk("t6_timeout_cleared", o_timeout,    0);
        chk("t6_result_held",     o_meas_valid, 1);
        chk_result("t6_held", 10, 3, 30);
        i_meas_ready = 1'b1;
        @(negedge CLK);
        chk("t6_accepted", o_meas_valid, 0);
        repeat (3) @(negedge CLK);
        chk("t6_idle_no_result", o_meas_valid, 0);
        i_en = 1'b1;
        repeat (2) @(negedge CLK);
        b      = rise_cnt;
        g_mode = 1;
        wait_valid(60, "t6_rearm_valid");
        chk("t6_latency", cyc - rise_at[(b + 1) % 256], LAT);
        chk_result("t6_rearm", 10, 3, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
